// File: rtl/rs_pkg.sv
// Shared types and helpers for the parametrised reservation station.
// Build option: define RS_WAKEUP_BYPASS_EN to let a slot issue in the same
// cycle its last operand arrives on the CDB (see param_reservation_station).
package rs_pkg;

  // Lifecycle of one reservation-station slot.
  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_WAIT  = 2'd1,
    SLOT_READY = 2'd2
  } slot_state_e;

  // True when every slot tag TAG_BASE..TAG_BASE+NUM_ENTRIES-1 fits in TAG_W bits.
  function automatic bit tag_range_ok(input int tag_base, input int num_entries,
                                      input int tag_w);
    return (tag_base + num_entries) <= (1 << tag_w);
  endfunction

  // True when the slot count is inside the supported range.
  function automatic bit entries_ok(input int num_entries);
    return (num_entries >= 2) && (num_entries <= 16);
  endfunction

endpackage

// File: rtl/param_reservation_station_if.sv
// Dispatch, CDB and issue signals of the reservation station.
// master = dispatch stage / CDB / FU side, slave = the reservation station.
interface param_reservation_station_if #(
  parameter int NUM_ENTRIES = 4,
  parameter int DATA_W      = 8,
  parameter int TAG_W       = 3
);
  localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  logic              disp_a_vld;
  logic [TAG_W-1:0]  disp_a_tag;
  logic [DATA_W-1:0] disp_a_data;
  logic              disp_b_vld;
  logic [TAG_W-1:0]  disp_b_tag;
  logic [DATA_W-1:0] disp_b_data;
  logic [TAG_W-1:0]  disp_alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              issue_valid;
  logic              issue_ready;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic [TAG_W-1:0]  issue_tag;
  logic              full;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output flush, disp_valid, disp_a_vld, disp_a_tag, disp_a_data,
           disp_b_vld, disp_b_tag, disp_b_data, cdb_valid, cdb_tag, cdb_data,
           issue_ready,
    input  disp_ready, disp_alloc_tag, issue_valid, issue_a, issue_b,
           issue_tag, full, occupancy
  );

  modport slave (
    input  flush, disp_valid, disp_a_vld, disp_a_tag, disp_a_data,
           disp_b_vld, disp_b_tag, disp_b_data, cdb_valid, cdb_tag, cdb_data,
           issue_ready,
    output disp_ready, disp_alloc_tag, issue_valid, issue_a, issue_b,
           issue_tag, full, occupancy
  );

endinterface

// File: rtl/rs_age_matrix.sv
// Age matrix: age_reg[i][j]=1 means slot i is older than slot j.
// Alloc makes a slot youngest, free clears its row/column, and the
// request vector is reduced to the one-hot oldest requester.
module rs_age_matrix #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [N-1:0] alloc_vec,
  input  logic [N-1:0] free_vec,
  input  logic [N-1:0] req,
  output logic [N-1:0] oldest
);

  logic [N-1:0][N-1:0] age_reg;
  logic [N-1:0][N-1:0] age_next;

  // Alloc first (new slot younger than everyone), then free clears its relations.
  always_comb begin
    age_next = age_reg;
    for (int k = 0; k < N; k++) begin
      if (alloc_vec[k]) begin
        for (int j = 0; j < N; j++) begin
          age_next[k][j] = 1'b0;
          age_next[j][k] = (j != k);
        end
      end
    end
    for (int f = 0; f < N; f++) begin
      if (free_vec[f]) begin
        for (int j = 0; j < N; j++) begin
          age_next[f][j] = 1'b0;
          age_next[j][f] = 1'b0;
        end
      end
    end
  end

  // Matrix register; reset and flush both forget all ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      age_reg <= '0;
    end else begin
      age_reg <= age_next;
    end
  end

  // A requester wins when it is older than every other requester.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_oldest
      localparam logic [N-1:0] SELF = N'(1) << gi;
      assign oldest[gi] = req[gi] && (&(age_reg[gi] | ~req | SELF));
    end
  endgenerate

endmodule

// File: rtl/param_reservation_station.sv
// Parametrised reservation station: NUM_ENTRIES two-operand slots that snoop
// the CDB for pending operands and issue the oldest ready slot to one FU.
// Build option RS_WAKEUP_BYPASS_EN: select uses post-wakeup readiness and
// forwards cdb_data to issue_a/b; otherwise a woken slot issues a cycle later.
module param_reservation_station
  import rs_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int DATA_W      = 8,
  parameter int TAG_W       = 3,
  parameter int TAG_BASE    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  param_reservation_station_if.slave  rs_if
);

  localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

  generate
    if (!tag_range_ok(TAG_BASE, NUM_ENTRIES, TAG_W) || !entries_ok(NUM_ENTRIES)) begin : g_bad_cfg
      $error("param_reservation_station: invalid NUM_ENTRIES/TAG_BASE/TAG_W");
    end
  endgenerate

  // Operand width depends on the instance parameters, so it lives here.
  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } operand_t;

  slot_state_e state_reg  [NUM_ENTRIES];
  slot_state_e state_next [NUM_ENTRIES];
  operand_t    opa_reg    [NUM_ENTRIES];
  operand_t    opa_next   [NUM_ENTRIES];
  operand_t    opb_reg    [NUM_ENTRIES];
  operand_t    opb_next   [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] busy, a_hit, b_hit, eligible, sel;
  logic [NUM_ENTRIES-1:0] alloc_oh, alloc_vec, free_vec;
  logic [DATA_W-1:0]      a_fwd [NUM_ENTRIES];
  logic [DATA_W-1:0]      b_fwd [NUM_ENTRIES];
  operand_t               disp_a_cap, disp_b_cap;
  logic                   disp_fire, issue_fire;
  logic [OCC_W-1:0]       occ;

  // Per-slot CDB compare, readiness and forwarded operand values.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_slot
      assign busy[gi]  = (state_reg[gi] != SLOT_FREE);
      assign a_hit[gi] = rs_if.cdb_valid && busy[gi] && !opa_reg[gi].vld &&
                         (opa_reg[gi].tag == rs_if.cdb_tag);
      assign b_hit[gi] = rs_if.cdb_valid && busy[gi] && !opb_reg[gi].vld &&
                         (opb_reg[gi].tag == rs_if.cdb_tag);
`ifdef RS_WAKEUP_BYPASS_EN
      assign eligible[gi] = busy[gi] && (opa_reg[gi].vld || a_hit[gi]) &&
                            (opb_reg[gi].vld || b_hit[gi]);
`else
      assign eligible[gi] = (state_reg[gi] == SLOT_READY);
`endif
      assign a_fwd[gi] = a_hit[gi] ? rs_if.cdb_data : opa_reg[gi].data;
      assign b_fwd[gi] = b_hit[gi] ? rs_if.cdb_data : opb_reg[gi].data;
    end
  endgenerate

  // Dispatched operands may be satisfied by the CDB in the same cycle.
  always_comb begin
    disp_a_cap.tag  = rs_if.disp_a_tag;
    disp_a_cap.vld  = rs_if.disp_a_vld;
    disp_a_cap.data = rs_if.disp_a_data;
    if (!rs_if.disp_a_vld && rs_if.cdb_valid && (rs_if.cdb_tag == rs_if.disp_a_tag)) begin
      disp_a_cap.vld  = 1'b1;
      disp_a_cap.data = rs_if.cdb_data;
    end
    disp_b_cap.tag  = rs_if.disp_b_tag;
    disp_b_cap.vld  = rs_if.disp_b_vld;
    disp_b_cap.data = rs_if.disp_b_data;
    if (!rs_if.disp_b_vld && rs_if.cdb_valid && (rs_if.cdb_tag == rs_if.disp_b_tag)) begin
      disp_b_cap.vld  = 1'b1;
      disp_b_cap.data = rs_if.cdb_data;
    end
  end

  // Lowest-index free slot receives the next dispatch.
  always_comb begin
    logic found;
    found                = 1'b0;
    alloc_oh             = '0;
    rs_if.disp_alloc_tag = TAG_W'(TAG_BASE);
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!found && !busy[i]) begin
        found                = 1'b1;
        alloc_oh[i]          = 1'b1;
        rs_if.disp_alloc_tag = TAG_W'(TAG_BASE + i);
      end
    end
  end

  assign rs_if.full        = &busy;
  assign rs_if.disp_ready  = !rs_if.full;
  assign disp_fire         = rs_if.disp_valid && rs_if.disp_ready;
  assign rs_if.issue_valid = |eligible;
  assign issue_fire        = rs_if.issue_valid && rs_if.issue_ready;
  assign alloc_vec         = alloc_oh & {NUM_ENTRIES{disp_fire}};
  assign free_vec          = sel & {NUM_ENTRIES{issue_fire}};

  rs_age_matrix #(
    .N (NUM_ENTRIES)
  ) u_age (
    .clk       (clk),
    .rst       (rst),
    .clr       (rs_if.flush),
    .alloc_vec (alloc_vec),
    .free_vec  (free_vec),
    .req       (eligible),
    .oldest    (sel)
  );

  // Output mux: OR of the one-hot selected slot, all zero when nothing issues.
  always_comb begin
    rs_if.issue_a   = '0;
    rs_if.issue_b   = '0;
    rs_if.issue_tag = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (sel[i]) begin
        rs_if.issue_a   = rs_if.issue_a | a_fwd[i];
        rs_if.issue_b   = rs_if.issue_b | b_fwd[i];
        rs_if.issue_tag = rs_if.issue_tag | TAG_W'(TAG_BASE + i);
      end
    end
  end

  // Busy-slot count.
  always_comb begin
    occ = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      occ = occ + OCC_W'(busy[i]);
    end
  end
  assign rs_if.occupancy = occ;

  // Slot next state: issue frees, busy slots wake, the allocated slot loads.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      state_next[i] = state_reg[i];
      opa_next[i]   = opa_reg[i];
      opb_next[i]   = opb_reg[i];
      if (issue_fire && sel[i]) begin
        state_next[i] = SLOT_FREE;
      end else if (busy[i]) begin
        if (a_hit[i]) begin
          opa_next[i].vld  = 1'b1;
          opa_next[i].data = rs_if.cdb_data;
        end
        if (b_hit[i]) begin
          opb_next[i].vld  = 1'b1;
          opb_next[i].data = rs_if.cdb_data;
        end
        state_next[i] = (opa_next[i].vld && opb_next[i].vld) ? SLOT_READY : SLOT_WAIT;
      end else if (alloc_vec[i]) begin
        opa_next[i]   = disp_a_cap;
        opb_next[i]   = disp_b_cap;
        state_next[i] = (disp_a_cap.vld && disp_b_cap.vld) ? SLOT_READY : SLOT_WAIT;
      end
    end
  end

  // Slot registers; flush has the same effect as reset and beats all updates.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (rst || rs_if.flush) begin
        state_reg[i] <= SLOT_FREE;
        opa_reg[i]   <= '0;
        opb_reg[i]   <= '0;
      end else begin
        state_reg[i] <= state_next[i];
        opa_reg[i]   <= opa_next[i];
        opb_reg[i]   <= opb_next[i];
      end
    end
  end

endmodule
